// File: rtl/div_rsub.sv
// Unsigned divider by repeated subtraction: dividend then divisor arrive on data_in
// on consecutive edges after start; one subtraction per clock until R < D.
module div_rsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADB = 2'd1,
    S_LOOP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    done_d  = done_q;
    dz_d    = dz_q;
    case (state_q)
      // DONE accepts a new start exactly like IDLE, enabling back-to-back ops.
      S_IDLE, S_DONE: begin
        if (start) begin
          r_d     = data_in;
          done_d  = 1'b0;
          dz_d    = 1'b0;
          state_d = S_LOADB;
        end
      end
      S_LOADB: begin
        d_d     = data_in;
        q_d     = '0;
        state_d = S_LOOP;
      end
      S_LOOP: begin
        if (d_q == '0) begin
          dz_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (r_q >= d_q) begin
          r_d = r_q - d_q;
          q_d = q_q + 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign quotient  = q_q;
  assign remainder = r_q;
  assign busy      = (state_q == S_LOADB) || (state_q == S_LOOP);
  assign done      = done_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_div_rsub.sv
// Directed-vector bench for div_rsub: results, latency, dz, ignored start, reset, back-to-back.
module tb_div_rsub;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dz;

  int checks;
  int failures;

  div_rsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation; edges counts clock edges after the start edge until done is seen.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int budget, output int edges, output bit timed_out);
    @(negedge clk);
    start   = 1'b1;
    data_in = a;
    @(negedge clk);
    start   = 1'b0;
    data_in = b;
    edges   = 0;
    while (!done && edges < budget) begin
      @(negedge clk);
      edges++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({quotient, remainder, busy, done, dz} !== {WIDTH*2+3{1'b0}}) begin
      failures++;
      $display("FAIL reset: q=%0h r=%0h busy=%b done=%b dz=%b required all 0",
               quotient, remainder, busy, done, dz);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] va[3] = '{16'd100, 16'd5, 16'd0};
    logic [WIDTH-1:0] vb[3] = '{16'd7, 16'd9, 16'd3};
    logic [WIDTH-1:0] eq[3] = '{16'd14, 16'd0, 16'd0};
    logic [WIDTH-1:0] er[3] = '{16'd2, 16'd5, 16'd0};
    int               el[3] = '{16, 2, 2};
    int edges;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 100, edges, to);
      checks++;
      if (to || quotient !== eq[i] || remainder !== er[i] || dz !== 1'b0 ||
          busy !== 1'b0 || edges != el[i]) begin
        failures++;
        $display("FAIL basic %0d/%0d: q=%0d r=%0d dz=%b busy=%b lat=%0d to=%b required q=%0d r=%0d dz=0 busy=0 lat=%0d",
                 va[i], vb[i], quotient, remainder, dz, busy, edges, to, eq[i], er[i], el[i]);
      end else
        $display("basic %0d/%0d -> q=%0d r=%0d lat=%0d", va[i], vb[i], quotient, remainder, edges);
    end
  endtask

  task automatic test_div_zero();
    int edges;
    bit to;
    run_op(16'h1234, 16'd0, 100, edges, to);
    checks++;
    if (to || dz !== 1'b1 || quotient !== 16'd0 || remainder !== 16'h1234 || edges != 2) begin
      failures++;
      $display("FAIL div_zero: dz=%b q=%0h r=%0h lat=%0d required dz=1 q=0 r=1234 lat=2",
               dz, quotient, remainder, edges);
    end else
      $display("div_zero 0x1234/0 -> dz=1 r=%0h", remainder);
    run_op(16'd10, 16'd3, 100, edges, to);
    checks++;
    if (to || dz !== 1'b0 || quotient !== 16'd3 || remainder !== 16'd1) begin
      failures++;
      $display("FAIL dz_clear: dz=%b q=%0d r=%0d required dz=0 q=3 r=1", dz, quotient, remainder);
    end else
      $display("dz_clear 10/3 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_max();
    int edges;
    bit to;
    run_op(16'hFFFF, 16'd1, 70000, edges, to);
    checks++;
    if (to || quotient !== 16'hFFFF || remainder !== 16'd0 || dz !== 1'b0 || edges != 65537) begin
      failures++;
      $display("FAIL max_div1: q=%0h r=%0h dz=%b lat=%0d to=%b required q=ffff r=0 dz=0 lat=65537",
               quotient, remainder, dz, edges, to);
    end else
      $display("max 0xffff/1 -> q=%0h lat=%0d", quotient, edges);
    run_op(16'hFFFF, 16'hFFFF, 100, edges, to);
    checks++;
    if (to || quotient !== 16'd1 || remainder !== 16'd0 || edges != 3) begin
      failures++;
      $display("FAIL max_self: q=%0d r=%0d lat=%0d required q=1 r=0 lat=3", quotient, remainder, edges);
    end else
      $display("max 0xffff/0xffff -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_start_ignored();
    int edges;
    @(negedge clk);
    start = 1'b1; data_in = 16'd50;
    @(negedge clk);
    start = 1'b0; data_in = 16'd5;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_start: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    edges = 0;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
      start   = edges[0];
      data_in = 16'(edges * 37 + 3);
    end
    start = 1'b0;
    checks++;
    if (!done || quotient !== 16'd10 || remainder !== 16'd0 || edges != 12) begin
      failures++;
      $display("FAIL start_ignored: done=%b q=%0d r=%0d lat=%0d required done=1 q=10 r=0 lat=12",
               done, quotient, remainder, edges);
    end else
      $display("start_ignored 50/5 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_reset_mid();
    int edges;
    bit to;
    @(negedge clk);
    start = 1'b1; data_in = 16'd1000;
    @(negedge clk);
    start = 1'b0; data_in = 16'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b1; data_in = 16'd77;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({quotient, remainder, busy, done, dz} !== {WIDTH*2+3{1'b0}}) begin
      failures++;
      $display("FAIL reset_mid: q=%0d r=%0d busy=%b done=%b dz=%b required all 0",
               quotient, remainder, busy, done, dz);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
    run_op(16'd9, 16'd4, 100, edges, to);
    checks++;
    if (to || quotient !== 16'd2 || remainder !== 16'd1) begin
      failures++;
      $display("FAIL after_reset: q=%0d r=%0d required q=2 r=1", quotient, remainder);
    end else
      $display("after_reset 9/4 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_back_to_back();
    int edges;
    @(negedge clk);
    start = 1'b1; data_in = 16'd20;
    @(negedge clk);
    data_in = 16'd6;
    @(negedge clk);
    data_in = 16'd30;
    edges = 1;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (!done || busy !== 1'b0 || quotient !== 16'd3 || remainder !== 16'd2 || edges != 5) begin
      failures++;
      $display("FAIL b2b_first: done=%b busy=%b q=%0d r=%0d lat=%0d required done=1 busy=0 q=3 r=2 lat=5",
               done, busy, quotient, remainder, edges);
    end else
      $display("b2b 20/6 -> q=%0d r=%0d", quotient, remainder);
    @(negedge clk);
    data_in = 16'd4;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done_drop: done=%b busy=%b required done=0 busy=1", done, busy);
    end
    @(negedge clk);
    start = 1'b0; data_in = 16'd0;
    edges = 1;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (!done || quotient !== 16'd7 || remainder !== 16'd2 || edges != 9) begin
      failures++;
      $display("FAIL b2b_second: done=%b q=%0d r=%0d lat=%0d required done=1 q=7 r=2 lat=9",
               done, quotient, remainder, edges);
    end else
      $display("b2b 30/4 -> q=%0d r=%0d", quotient, remainder);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; data_in = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_max();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_rsub.md
# div_rsub

Unsigned integer divider using repeated subtraction; the inverse counterpart of the team's repeated-addition multiplier. It uses the same operand-bus and handshake: a single shared `data_in` bus delivers dividend then divisor on consecutive cycles after `start`. The block contains a remainder register, divisor register, quotient up-counter, subtractor/comparator and a controller FSM. It produces quotient, remainder, a divide-by-zero flag and a sticky `done`.

## Interface
- `WIDTH`, default 16, operand/result width in bits (unsigned)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous reset, active-high
- `start`  input  1  begin operation; sampled only in IDLE or DONE
- `data_in`  input  WIDTH  operand bus: dividend on start edge, divisor on following edge
- `quotient`  output  WIDTH  quotient register (final when `done`=1)
- `remainder`  output  WIDTH  remainder register (final when `done`=1)
- `busy`  output  1  high in LOADB and LOOP
- `done`  output  1  high in DONE; holds until next accepted `start` or reset
- `dz`  output  1  divide-by-zero flag; valid with `done`
- One clock (`clk`); reset `rst` is synchronous and active-high.

## Operation
- Registers: R (remainder, drives `remainder`), D (divisor), Q (quotient counter, drives `quotient`), state, `done`, `dz`. All outputs registered or decoded from state.
- Reset (rst=1 at edge, overrides everything): state=IDLE, R=0, D=0, Q=0, done=0, dz=0, busy=0.
- IDLE: if start=1: R<=data_in, done<=0, dz<=0, ->LOADB; else hold.
- LOADB: D<=data_in, Q<=0, ->LOOP. `start` ignored.
- LOOP (evaluated each edge):
  - if D==0: dz<=1, done<=1, ->DONE (Q=0, R=dividend unchanged).
  - else if R>=D: R<=R-D, Q<=Q+1, stay.
  - else: done<=1, ->DONE.
- DONE: outputs hold; start=1 behaves exactly as in IDLE (captures new dividend, clears done/dz, ->LOADB).
- Arithmetic: unsigned, full WIDTH compare; R-D never underflows (guarded by R>=D); Q cannot overflow since Q<=dividend.
- `start` while busy=1: ignored, no effect on operation.
- Unused state encodings: -> IDLE on next edge, registers unchanged.

## Timing
- Edge E0: start sampled (IDLE/DONE). E1: divisor captured. E2..E(1+q): one subtraction per edge (q = final quotient). E(2+q): terminating compare; `done` high after this edge.
- Latency start-edge to done: q+2 edges; minimum 2 (q=0 or D==0).
- Worst case: dividend 2^WIDTH-1, divisor 1 -> 2^WIDTH+1 edges; no timeout.
- `busy` high from after E0 through edge E(2+q); `busy` and `done` never both high.
- Back-to-back: start held high in DONE starts next op on the first DONE edge; done drops after that edge.
- Reset mid-operation: next edge returns all registers to reset values regardless of state; start on that same edge ignored.
- `quotient`/`remainder` show intermediate values while busy; only consumed when done=1.

## Test plan
- Dividend 100, divisor 7 (WIDTH=16) -> quotient 14, remainder 2, dz 0, done high 16 edges after start edge.
- Dividend 5, divisor 9 -> quotient 0, remainder 5, done after 2 edges; dividend 0, divisor 3 -> 0/0.
- Dividend 0x1234, divisor 0 -> dz 1, quotient 0, remainder 0x1234, done after 2 edges; next start with 10/3 clears dz -> 3 r1.
- Dividend 0xFFFF, divisor 1 -> quotient 0xFFFF, remainder 0, done after 65537 edges; divisor 0xFFFF -> 1 r0.
- Pulse start and change data_in during LOOP of 50/5 -> result 10 r0 unaffected; rst asserted mid-LOOP -> next edge all outputs 0, state IDLE, later 9/4 -> 2 r1.
- start held high continuously with data alternating 20,6,30,4 -> 3 r2 then 7 r2, done pulses between operations.
